// File: rtl/param_counter_n_if.sv
// Control/status bundle for param_counter_n.
// The counter width is derived here from the modulus so that the interface
// and the counter always agree on the width of cnt and load_val.
interface param_counter_n_if #(
    parameter int UPPER_BOUND = 8
);
    localparam int W = (UPPER_BOUND > 1) ? $clog2(UPPER_BOUND) : 1;

    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] cnt;
    logic         tc;

    // master drives the controls and observes the count
    modport master (
        output en, up, load, load_val,
        input  cnt, tc
    );

    // slave is the counter itself
    modport slave (
        input  en, up, load, load_val,
        output cnt, tc
    );
endinterface

// File: rtl/param_counter_n.sv
// Modulo-N up/down counter with enable, synchronous saturating load and a
// combinational terminal-count strobe. The count runs 0..UPPER_BOUND-1; for
// non-power-of-two moduli the codes above UPPER_BOUND-1 are never reached
// because every wrap and clamp compares against UPPER_BOUND-1.
module param_counter_n #(
    parameter int UPPER_BOUND = 8
) (
    input  logic              clk,
    input  logic              rst,
    param_counter_n_if.slave  bus
);
    localparam int           W   = (UPPER_BOUND > 1) ? $clog2(UPPER_BOUND) : 1;
    localparam logic [W-1:0] MAX = W'(UPPER_BOUND - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] load_clamped;

    // Out-of-range load values saturate to the top of the count range.
    assign load_clamped = (bus.load_val > MAX) ? MAX : bus.load_val;

    // Count register: reset beats load, load beats counting, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (bus.load) begin
            cnt_q <= load_clamped;
        end else if (bus.en) begin
            if (bus.up) begin
                cnt_q <= (cnt_q == MAX) ? '0 : cnt_q + W'(1);
            end else begin
                cnt_q <= (cnt_q == '0) ? MAX : cnt_q - W'(1);
            end
        end
    end

    assign bus.cnt = cnt_q;

    // Flags the cycle whose next enabled edge wraps; load and reset do not
    // affect it. With a modulus of 1 both compares hold, so tc follows en.
    assign bus.tc = bus.en & (bus.up ? (cnt_q == MAX) : (cnt_q == '0));

endmodule

// File: tb/tb_param_counter_n.sv
// Directed bench for param_counter_n: three instances (N=8, N=10, N=1)
// driven from a vector table, plus hand-written sequences for the
// combinational tc path and the load clamp.
module tb_param_counter_n;

    logic clk;
    logic rst8, rst10, rst1;

    param_counter_n_if #(.UPPER_BOUND(8))  b8  ();
    param_counter_n_if #(.UPPER_BOUND(10)) b10 ();
    param_counter_n_if #(.UPPER_BOUND(1))  b1  ();

    param_counter_n #(.UPPER_BOUND(8))  dut8  (.clk(clk), .rst(rst8),  .bus(b8));
    param_counter_n #(.UPPER_BOUND(10)) dut10 (.clk(clk), .rst(rst10), .bus(b10));
    param_counter_n #(.UPPER_BOUND(1))  dut1  (.clk(clk), .rst(rst1),  .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dut;   // 0: N=8, 1: N=10, 2: N=1
        logic       rst;
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] lv;
        logic [3:0] exp_cnt;
        logic       exp_tc;
    } vec_t;

    vec_t tbl[$];
    int total = 0;
    int bad   = 0;

    function automatic void add(int d, logic r, logic e, logic u, logic l,
                                int lv, int c, logic t);
        vec_t v;
        v.dut = d; v.rst = r; v.en = e; v.up = u; v.load = l;
        v.lv = 4'(lv); v.exp_cnt = 4'(c); v.exp_tc = t;
        tbl.push_back(v);
    endfunction

    task automatic check(string name, int got, int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic read(input int d, output logic [3:0] c, output logic t);
        case (d)
            0:       begin c = 4'(b8.cnt);  t = b8.tc;  end
            1:       begin c = b10.cnt;     t = b10.tc; end
            default: begin c = 4'(b1.cnt);  t = b1.tc;  end
        endcase
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [3:0] c;
        logic       t;
        case (v.dut)
            0: begin
                rst8 = v.rst; b8.en = v.en; b8.up = v.up;
                b8.load = v.load; b8.load_val = v.lv[2:0];
            end
            1: begin
                rst10 = v.rst; b10.en = v.en; b10.up = v.up;
                b10.load = v.load; b10.load_val = v.lv;
            end
            default: begin
                rst1 = v.rst; b1.en = v.en; b1.up = v.up;
                b1.load = v.load; b1.load_val = v.lv[0];
            end
        endcase
        @(posedge clk);
        #1;
        read(v.dut, c, t);
        check($sformatf("vec%0d_n%0d_cnt", idx, v.dut), int'(c), int'(v.exp_cnt));
        check($sformatf("vec%0d_n%0d_tc", idx, v.dut), int'(t), int'(v.exp_tc));
    endtask

    initial begin
        logic [3:0] c;
        logic       t;

        rst8 = 1'b0; rst10 = 1'b0; rst1 = 1'b0;
        b8.en  = 1'b0; b8.up  = 1'b1; b8.load  = 1'b0; b8.load_val  = '0;
        b10.en = 1'b0; b10.up = 1'b1; b10.load = 1'b0; b10.load_val = '0;
        b1.en  = 1'b0; b1.up  = 1'b1; b1.load  = 1'b0; b1.load_val  = '0;

        // ---- N=8: reset then count up through the wrap
        add(0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1);          // tc after reset = en & !up
        add(0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) add(0, 1, 1, 1, 0, 0, i % 8, (i % 8) == 7);
        // ---- N=8: count down from reset
        add(0, 0, 1, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 9; i++) add(0, 1, 1, 0, 0, 0, (16 - i) % 8, ((16 - i) % 8) == 0);
        // ---- N=8: hold at 3 with en=0, then resume
        add(0, 1, 1, 1, 1, 3, 3, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1, 0, 0, 3, 0);
        add(0, 1, 1, 1, 0, 0, 4, 0);
        // ---- N=8: reset beats load, load beats wrap
        add(0, 1, 1, 1, 1, 7, 7, 1);
        add(0, 0, 1, 1, 1, 2, 0, 0);
        add(0, 1, 1, 1, 1, 7, 7, 1);
        add(0, 1, 1, 1, 1, 2, 2, 0);
        // ---- N=8: direction changes, load ignores en
        add(0, 1, 1, 0, 0, 0, 1, 0);
        add(0, 1, 1, 0, 0, 0, 0, 1);
        add(0, 1, 1, 1, 0, 0, 1, 0);
        add(0, 1, 0, 0, 1, 5, 5, 0);
        // ---- N=10: up through wrap, clamp and plain load, down wrap
        add(1, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 11; i++) add(1, 1, 1, 1, 0, 0, i % 10, (i % 10) == 9);
        add(1, 1, 1, 1, 1, 13, 9, 1);
        add(1, 1, 1, 1, 1, 5, 5, 0);
        add(1, 1, 1, 0, 1, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0, 9, 0);
        add(1, 1, 0, 1, 1, 15, 9, 0);
        // ---- N=1: always 0, tc follows en
        add(2, 0, 1, 1, 0, 0, 0, 1);
        add(2, 1, 1, 1, 0, 0, 0, 1);
        add(2, 1, 0, 1, 0, 0, 0, 0);
        add(2, 1, 1, 0, 0, 0, 0, 1);
        add(2, 1, 1, 1, 1, 1, 0, 1);
        add(2, 1, 0, 0, 1, 1, 0, 0);

        foreach (tbl[i]) apply(tbl[i], i);

        // ---- tc is combinational from cnt/en/up with no edge in between
        rst8 = 1'b1; b8.load = 1'b1; b8.load_val = 3'd7; b8.en = 1'b1; b8.up = 1'b1;
        @(posedge clk); #1;
        b8.load = 1'b0;
        check("comb_tc_up_at7", int'(b8.tc), 1);
        b8.en = 1'b0; #1;
        check("comb_tc_en0", int'(b8.tc), 0);
        b8.en = 1'b1; b8.up = 1'b0; #1;
        check("comb_tc_down_at7", int'(b8.tc), 0);
        b8.up = 1'b1; #1;
        check("comb_tc_back_up", int'(b8.tc), 1);
        @(posedge clk); #1;
        check("wrap_after_comb", int'(b8.cnt), 0);

        // ---- N=10 load clamp across every out-of-range code
        rst10 = 1'b1; b10.en = 1'b0; b10.up = 1'b1;
        for (int v = 10; v < 16; v++) begin
            b10.load = 1'b1; b10.load_val = 4'(v);
            @(posedge clk); #1;
            check($sformatf("clamp10_lv%0d", v), int'(b10.cnt), 9);
            b10.load = 1'b1; b10.load_val = 4'd0;
            @(posedge clk); #1;
            read(1, c, t);
            check($sformatf("clamp10_zero_after%0d", v), int'(c), 0);
        end
        b10.load = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
